// File: rtl/reg_file_wb_demux.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wb_demux
// Purpose  : Integer register file with a 1-to-NREG write-back demux and two
//            combinational read ports, with optional WB-to-ID write-through.
// Revision : 1.0  initial release
// ============================================================================
module reg_file_wb_demux #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam int c_DEPTH = 1 << AW;

  // x0 has no storage; only x1..x(NREG-1) are flops.
  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic [XLEN-1:0] regs_d [1:NREG-1];
  logic [XLEN-1:0] w_rf   [c_DEPTH];
  logic            w_hit1;
  logic            w_hit2;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  always_comb begin
    for (int k = 1; k < NREG; k++) begin
      regs_d[k] = regs_q[k];
      if (we && (waddr == AW'(k))) begin
        regs_d[k] = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < NREG; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Full 2**AW-entry view so the read mux never indexes past the storage.
  genvar j;
  for (j = 0; j < c_DEPTH; j++) begin : g_rf
    if ((j >= 1) && (j < NREG)) begin : g_impl
      assign w_rf[j] = regs_q[j];
    end else begin : g_zero
      assign w_rf[j] = '0;
    end
  end

  always_comb begin
    w_hit1 = BYPASS && rst_n && we && (waddr == raddr1) && addr_ok(raddr1);
    w_hit2 = BYPASS && rst_n && we && (waddr == raddr2) && addr_ok(raddr2);
    rdata1 = w_hit1 ? wdata : w_rf[raddr1];
    rdata2 = w_hit2 ? wdata : w_rf[raddr2];
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_wb_demux
// Purpose  : Scoreboard bench for two register-file configurations:
//            A = 32 regs with bypass, B = 16 regs without bypass.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_wb_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_wb_demux #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_a), .rdata2(rdata2_a)
  );

  reg_file_wb_demux #(.XLEN(32), .NREG(16), .AW(5), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b)
  );

  // Reference: plain arrays of architectural state, one per configuration.
  logic [31:0] ma [32];
  logic [31:0] mb [16];

  typedef struct {
    logic [31:0] e1a, e2a, e1b, e2b;
    int          a1, a2;
  } exp_t;
  exp_t q[$];

  function automatic logic [31:0] ref_rd(input int a, input bit cfg_b);
    int nreg = cfg_b ? 16 : 32;
    if (!rst_n || a == 0 || a >= nreg) return 32'd0;
    if (!cfg_b && we && int'(waddr) == a) return wdata;
    return cfg_b ? mb[a] : ma[a];
  endfunction

  task automatic step(input bit r, input bit w, input int wa, input logic [31:0] wd,
                      input int ra1, input int ra2);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n  = r;
    we     = w;
    waddr  = 5'(wa);
    wdata  = wd;
    raddr1 = 5'(ra1);
    raddr2 = 5'(ra2);
    if (!rst_n) begin
      foreach (ma[i]) ma[i] = '0;
      foreach (mb[i]) mb[i] = '0;
    end
    e.a1  = ra1;
    e.a2  = ra2;
    e.e1a = ref_rd(ra1, 1'b0);
    e.e2a = ref_rd(ra2, 1'b0);
    e.e1b = ref_rd(ra1, 1'b1);
    e.e2b = ref_rd(ra2, 1'b1);
    q.push_back(e);
    if (rst_n && we && wa != 0) begin
      if (wa < 32) ma[wa] = wd;
      if (wa < 16) mb[wa] = wd;
    end
  endtask

  task automatic chk(input string nm, input int a, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s addr=%0d got=%h expected=%h t=%0t", nm, a, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("a_rdata1", e.a1, rdata1_a, e.e1a);
      chk("a_rdata2", e.a2, rdata2_a, e.e2a);
      chk("b_rdata1", e.a1, rdata1_b, e.e1b);
      chk("b_rdata2", e.a2, rdata2_b, e.e2b);
    end
  end

  initial begin
    foreach (ma[i]) ma[i] = '0;
    foreach (mb[i]) mb[i] = '0;

    step(0, 0, 0, 0, 5, 0);
    step(0, 1, 5, 32'h1234_5678, 5, 5);
    // Write x5, read it back, then drop reset while still addressing it.
    step(1, 1, 5, 32'hDEAD_BEEF, 5, 5);
    step(1, 0, 0, 0, 5, 5);
    step(0, 0, 0, 0, 5, 5);
    step(1, 1, 5, 32'd1, 5, 5);
    step(1, 0, 0, 0, 5, 5);

    step(1, 1, 0, 32'hFFFF_FFFF, 0, 5);
    step(1, 0, 0, 0, 0, 5);

    for (int k = 1; k < 32; k++) step(1, 1, k, 32'(k) * 32'h0101_0101, k, k - 1);
    for (int k = 0; k < 32; k++) step(1, 0, 0, 0, k, 31 - k);

    step(1, 1, 7, 32'd3, 0, 0);
    step(1, 1, 7, 32'd9, 0, 7);
    step(1, 0, 0, 0, 7, 7);

    step(1, 0, 4, 32'd55, 4, 4);
    step(1, 0, 0, 0, 4, 4);
    step(1, 1, 20, 32'd123, 20, 20);
    step(1, 0, 0, 0, 20, 20);

    for (int n = 0; n < 10000; n++) begin
      step(($urandom_range(0, 499) != 0), $urandom_range(0, 1),
           $urandom_range(0, 31), $urandom(),
           $urandom_range(0, 31), $urandom_range(0, 31));
    end
    step(1, 0, 0, 0, 0, 0);

    for (int t = 0; t < 5 && q.size() > 0; t++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
